// File: rtl/reservation_multi_cdb_if.sv
// Dispatch, CDB snoop and issue bundle of the ALU reservation station.
// master = dispatch/CDB/ALU side, slave = the reservation station.
interface reservation_multi_cdb_if #(
    parameter int unsigned RS_DEPTH  = 16,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROB_TAG_W = 4,
    parameter int unsigned OP_W      = 6
);
    localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

    logic                          assignment_ena;
    logic [OP_W-1:0]               in_op;
    logic [ROB_TAG_W-1:0]          in_Qj;
    logic [ROB_TAG_W-1:0]          in_Qk;
    logic [DATA_W-1:0]             in_Vj;
    logic [DATA_W-1:0]             in_Vk;
    logic [DATA_W-1:0]             in_pc;
    logic [DATA_W-1:0]             in_imm;
    logic [ROB_TAG_W-1:0]          in_rd_rob;
    logic [NUM_CDB-1:0]            in_cdb_valid;
    logic [NUM_CDB*ROB_TAG_W-1:0]  in_cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]     in_cdb_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [OP_W-1:0]               out_op;
    logic [DATA_W-1:0]             out_Vj;
    logic [DATA_W-1:0]             out_Vk;
    logic [ROB_TAG_W-1:0]          out_rob_tag;
    logic [DATA_W-1:0]             out_pc;
    logic [DATA_W-1:0]             out_imm;
    logic                          has_capacity;
    logic [CNT_W-1:0]              free_count;

    modport master (
        output assignment_ena, in_op, in_Qj, in_Qk, in_Vj, in_Vk, in_pc, in_imm, in_rd_rob,
        output in_cdb_valid, in_cdb_tag, in_cdb_data, out_ready,
        input  out_valid, out_op, out_Vj, out_Vk, out_rob_tag, out_pc, out_imm,
        input  has_capacity, free_count
    );

    modport slave (
        input  assignment_ena, in_op, in_Qj, in_Qk, in_Vj, in_Vk, in_pc, in_imm, in_rd_rob,
        input  in_cdb_valid, in_cdb_tag, in_cdb_data, out_ready,
        output out_valid, out_op, out_Vj, out_Vk, out_rob_tag, out_pc, out_imm,
        output has_capacity, free_count
    );
endinterface

// File: rtl/reservation_multi_cdb.sv
// ALU reservation station with multi-channel CDB wakeup and a registered issue slot.
// Define RS_OLDEST_FIRST_EN for oldest-ready issue via an age matrix; default is lowest-index.
module reservation_multi_cdb #(
    parameter int unsigned RS_DEPTH  = 16,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROB_TAG_W = 4,
    parameter int unsigned OP_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   flush,
    reservation_multi_cdb_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);
    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0]  busy_q, busy_d;
    logic [OP_W-1:0]      op_q  [RS_DEPTH], op_d  [RS_DEPTH];
    logic [ROB_TAG_W-1:0] qj_q  [RS_DEPTH], qj_d  [RS_DEPTH];
    logic [ROB_TAG_W-1:0] qk_q  [RS_DEPTH], qk_d  [RS_DEPTH];
    logic [ROB_TAG_W-1:0] rob_q [RS_DEPTH], rob_d [RS_DEPTH];
    logic [DATA_W-1:0]    vj_q  [RS_DEPTH], vj_d  [RS_DEPTH];
    logic [DATA_W-1:0]    vk_q  [RS_DEPTH], vk_d  [RS_DEPTH];
    logic [DATA_W-1:0]    pc_q  [RS_DEPTH], pc_d  [RS_DEPTH];
    logic [DATA_W-1:0]    imm_q [RS_DEPTH], imm_d [RS_DEPTH];
`ifdef RS_OLDEST_FIRST_EN
    // older_q[j][i] set: entry j was dispatched before entry i
    logic [RS_DEPTH-1:0]  older_q [RS_DEPTH], older_d [RS_DEPTH];
`endif

    logic                 out_valid_q, out_valid_d;
    logic [OP_W-1:0]      out_op_q, out_op_d;
    logic [DATA_W-1:0]    out_vj_q, out_vj_d, out_vk_q, out_vk_d;
    logic [DATA_W-1:0]    out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [ROB_TAG_W-1:0] out_rob_q, out_rob_d;
    logic [CNT_W-1:0]     free_q, free_d;

    logic [RS_DEPTH-1:0]  ready_c;
    logic                 sel_found_c;
    logic [IDX_W-1:0]     sel_idx_c;
    logic [IDX_W-1:0]     free_idx_c;
    logic                 has_cap_c;
    logic                 issue_c;
    logic                 disp_c;

    // Lowest-index valid channel carrying a nonzero matching tag; MSB flags a hit.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]           vld,
        input logic [NUM_CDB*ROB_TAG_W-1:0] tags,
        input logic [NUM_CDB*DATA_W-1:0]    data
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (vld[c] && (tag != '0) && (tags[c*ROB_TAG_W +: ROB_TAG_W] == tag))
                res = {1'b1, data[c*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    always_comb begin
        ready_c = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            ready_c[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end

    assign has_cap_c = !(&busy_q);

    // Issue candidate and lowest free slot, both from registered state only.
    always_comb begin : pick
`ifdef RS_OLDEST_FIRST_EN
        logic [RS_DEPTH-1:0] older_ready;
        older_ready = '0;
`endif
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        free_idx_c  = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
`ifdef RS_OLDEST_FIRST_EN
            older_ready = '0;
            for (int j = 0; j < RS_DEPTH; j++)
                older_ready[j] = ready_c[j] && older_q[j][i];
            if (ready_c[i] && (older_ready == '0)) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDX_W'(i);
            end
`else
            if (ready_c[i]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDX_W'(i);
            end
`endif
            if (!busy_q[i])
                free_idx_c = IDX_W'(i);
        end
    end

    always_comb begin : next_state
        logic [DATA_W:0] hit_j;
        logic [DATA_W:0] hit_k;
        hit_j       = '0;
        hit_k       = '0;
        busy_d      = busy_q;
        op_d        = op_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        rob_d       = rob_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
`ifdef RS_OLDEST_FIRST_EN
        older_d     = older_q;
`endif
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_vj_d    = out_vj_q;
        out_vk_d    = out_vk_q;
        out_pc_d    = out_pc_q;
        out_imm_d   = out_imm_q;
        out_rob_d   = out_rob_q;
        free_d      = free_q;
        issue_c     = 1'b0;
        disp_c      = 1'b0;

        if (flush) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
            out_op_d    = '0;
            out_vj_d    = '0;
            out_vk_d    = '0;
            out_pc_d    = '0;
            out_imm_d   = '0;
            out_rob_d   = '0;
            free_d      = CNT_W'(RS_DEPTH);
`ifdef RS_OLDEST_FIRST_EN
            for (int i = 0; i < RS_DEPTH; i++)
                older_d[i] = '0;
`endif
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy_q[i]) begin
                    hit_j = cdb_lookup(qj_q[i], bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
                    hit_k = cdb_lookup(qk_q[i], bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
                    if (hit_j[DATA_W]) begin
                        qj_d[i] = '0;
                        vj_d[i] = hit_j[DATA_W-1:0];
                    end
                    if (hit_k[DATA_W]) begin
                        qk_d[i] = '0;
                        vk_d[i] = hit_k[DATA_W-1:0];
                    end
                end
            end

            // Issue slot refills whenever it is empty or being consumed.
            if (!out_valid_q || bus.out_ready) begin
                out_valid_d = sel_found_c;
                if (sel_found_c) begin
                    issue_c           = 1'b1;
                    busy_d[sel_idx_c] = 1'b0;
                    out_op_d          = op_q[sel_idx_c];
                    out_vj_d          = vj_q[sel_idx_c];
                    out_vk_d          = vk_q[sel_idx_c];
                    out_pc_d          = pc_q[sel_idx_c];
                    out_imm_d         = imm_q[sel_idx_c];
                    out_rob_d         = rob_q[sel_idx_c];
`ifdef RS_OLDEST_FIRST_EN
                    older_d[sel_idx_c] = '0;
                    for (int j = 0; j < RS_DEPTH; j++)
                        older_d[j][sel_idx_c] = 1'b0;
`endif
                end
            end

            if (bus.assignment_ena && has_cap_c) begin
                disp_c = 1'b1;
                hit_j  = cdb_lookup(bus.in_Qj, bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
                hit_k  = cdb_lookup(bus.in_Qk, bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
`ifdef RS_OLDEST_FIRST_EN
                older_d[free_idx_c] = '0;
                for (int j = 0; j < RS_DEPTH; j++)
                    older_d[j][free_idx_c] = busy_d[j];
`endif
                busy_d[free_idx_c] = 1'b1;
                op_d[free_idx_c]   = bus.in_op;
                rob_d[free_idx_c]  = bus.in_rd_rob;
                pc_d[free_idx_c]   = bus.in_pc;
                imm_d[free_idx_c]  = bus.in_imm;
                qj_d[free_idx_c]   = hit_j[DATA_W] ? '0 : bus.in_Qj;
                vj_d[free_idx_c]   = hit_j[DATA_W] ? hit_j[DATA_W-1:0] : bus.in_Vj;
                qk_d[free_idx_c]   = hit_k[DATA_W] ? '0 : bus.in_Qk;
                vk_d[free_idx_c]   = hit_k[DATA_W] ? hit_k[DATA_W-1:0] : bus.in_Vk;
            end

            free_d = free_q + CNT_W'(issue_c) - CNT_W'(disp_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            op_q        <= '{default: '0};
            qj_q        <= '{default: '0};
            qk_q        <= '{default: '0};
            rob_q       <= '{default: '0};
            vj_q        <= '{default: '0};
            vk_q        <= '{default: '0};
            pc_q        <= '{default: '0};
            imm_q       <= '{default: '0};
`ifdef RS_OLDEST_FIRST_EN
            older_q     <= '{default: '0};
`endif
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_vj_q    <= '0;
            out_vk_q    <= '0;
            out_pc_q    <= '0;
            out_imm_q   <= '0;
            out_rob_q   <= '0;
            free_q      <= CNT_W'(RS_DEPTH);
        end else if (ena) begin
            busy_q      <= busy_d;
            op_q        <= op_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            rob_q       <= rob_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
`ifdef RS_OLDEST_FIRST_EN
            older_q     <= older_d;
`endif
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_vj_q    <= out_vj_d;
            out_vk_q    <= out_vk_d;
            out_pc_q    <= out_pc_d;
            out_imm_q   <= out_imm_d;
            out_rob_q   <= out_rob_d;
            free_q      <= free_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_op       = out_op_q;
    assign bus.out_Vj       = out_vj_q;
    assign bus.out_Vk       = out_vk_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_imm      = out_imm_q;
    assign bus.out_rob_tag  = out_rob_q;
    assign bus.has_capacity = has_cap_c;
    assign bus.free_count   = free_q;
endmodule

// File: tb/tb_reservation_multi_cdb.sv
// Scoreboard bench for reservation_multi_cdb: directed scenarios plus random traffic
// against a slot/sequence-number reference model.
module tb_reservation_multi_cdb;
    localparam int unsigned RS_DEPTH  = 16;
    localparam int unsigned NUM_CDB   = 2;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned OP_W      = 6;
`ifdef RS_OLDEST_FIRST_EN
    localparam bit OLDEST = 1'b1;
`else
    localparam bit OLDEST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, ena, flush;

    reservation_multi_cdb_if #(.RS_DEPTH(RS_DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W),
                               .ROB_TAG_W(ROB_TAG_W), .OP_W(OP_W)) bus ();

    reservation_multi_cdb #(.RS_DEPTH(RS_DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W),
                            .ROB_TAG_W(ROB_TAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    vj;
        logic [DATA_W-1:0]    vk;
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    imm;
        logic [ROB_TAG_W-1:0] rob;
    } iss_t;

    typedef struct packed {
        logic                 busy;
        logic [31:0]          seq;
        logic [ROB_TAG_W-1:0] qj;
        logic [ROB_TAG_W-1:0] qk;
        iss_t                 d;
    } ent_t;

    ent_t   m_ent [RS_DEPTH];
    logic   m_ov;
    iss_t   m_out;
    int unsigned m_seq_ctr;
    logic   cur_ov;
    iss_t   cur_out;
    int     cur_free;
    iss_t   exp_q [$];
    logic [ROB_TAG_W-1:0] iss_log [$];

    logic                 cdb_v [NUM_CDB];
    logic [ROB_TAG_W-1:0] cdb_t [NUM_CDB];
    logic [DATA_W-1:0]    cdb_d [NUM_CDB];

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int count_free();
        int n = 0;
        for (int i = 0; i < RS_DEPTH; i++)
            if (!m_ent[i].busy) n++;
        return n;
    endfunction

    // First listed channel that is valid and carries the nonzero tag supplies the value.
    function automatic bit cdb_hit(input logic [ROB_TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        bit hit = 1'b0;
        d = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (!hit && t != 0 && cdb_v[c] && cdb_t[c] == t) begin
                hit = 1'b1;
                d   = cdb_d[c];
            end
        end
        return hit;
    endfunction

    task automatic model_step();
        int sel = -1;
        int fre = -1;
        logic [DATA_W-1:0] d;
        if (rst || (ena && flush)) begin
            for (int i = 0; i < RS_DEPTH; i++) m_ent[i].busy = 1'b0;
            m_ov  = 1'b0;
            m_out = '0;
        end else if (ena) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (m_ent[i].busy && m_ent[i].qj == 0 && m_ent[i].qk == 0)
                    if (sel < 0 || (OLDEST && m_ent[i].seq < m_ent[sel].seq)) sel = i;
                if (!m_ent[i].busy && fre < 0) fre = i;
            end
            if (m_ov && bus.out_ready) exp_q.push_back(m_out);
            if (!m_ov || bus.out_ready) begin
                m_ov = (sel >= 0);
                if (sel >= 0) begin
                    m_out = m_ent[sel].d;
                    m_ent[sel].busy = 1'b0;
                end
            end
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (m_ent[i].busy) begin
                    if (cdb_hit(m_ent[i].qj, d)) begin m_ent[i].qj = '0; m_ent[i].d.vj = d; end
                    if (cdb_hit(m_ent[i].qk, d)) begin m_ent[i].qk = '0; m_ent[i].d.vk = d; end
                end
            end
            if (bus.assignment_ena && fre >= 0) begin
                m_ent[fre].busy  = 1'b1;
                m_ent[fre].seq   = m_seq_ctr;
                m_seq_ctr++;
                m_ent[fre].d.op  = bus.in_op;
                m_ent[fre].d.pc  = bus.in_pc;
                m_ent[fre].d.imm = bus.in_imm;
                m_ent[fre].d.rob = bus.in_rd_rob;
                m_ent[fre].qj    = bus.in_Qj;
                m_ent[fre].d.vj  = bus.in_Vj;
                m_ent[fre].qk    = bus.in_Qk;
                m_ent[fre].d.vk  = bus.in_Vk;
                if (cdb_hit(bus.in_Qj, d)) begin m_ent[fre].qj = '0; m_ent[fre].d.vj = d; end
                if (cdb_hit(bus.in_Qk, d)) begin m_ent[fre].qk = '0; m_ent[fre].d.vk = d; end
            end
        end
    endtask

    // Present inputs for the next edge, advance the model, then settle past the edge.
    task automatic tick();
        for (int c = 0; c < NUM_CDB; c++) begin
            bus.in_cdb_valid[c]                          = cdb_v[c];
            bus.in_cdb_tag[c*ROB_TAG_W +: ROB_TAG_W]     = cdb_t[c];
            bus.in_cdb_data[c*DATA_W +: DATA_W]          = cdb_d[c];
        end
        model_step();
        @(posedge clk);
        #2;
        cur_ov   = m_ov;
        cur_out  = m_out;
        cur_free = count_free();
    endtask

    task automatic set_idle();
        ena = 1'b1;
        flush = 1'b0;
        bus.assignment_ena = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_op = '0; bus.in_Qj = '0; bus.in_Qk = '0; bus.in_Vj = '0; bus.in_Vk = '0;
        bus.in_pc = '0; bus.in_imm = '0; bus.in_rd_rob = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            cdb_v[c] = 1'b0; cdb_t[c] = '0; cdb_d[c] = '0;
        end
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [ROB_TAG_W-1:0] qj,
                            input logic [ROB_TAG_W-1:0] qk, input logic [DATA_W-1:0] vj,
                            input logic [DATA_W-1:0] vk, input logic [ROB_TAG_W-1:0] rob);
        bus.assignment_ena = 1'b1;
        bus.in_op = op; bus.in_Qj = qj; bus.in_Qk = qk; bus.in_Vj = vj; bus.in_Vk = vk;
        bus.in_rd_rob = rob; bus.in_pc = $urandom; bus.in_imm = $urandom;
    endtask

    task automatic set_cdb(input int c, input logic [ROB_TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_v[c] = 1'b1; cdb_t[c] = t; cdb_d[c] = d;
    endtask

    function automatic logic [ROB_TAG_W-1:0] rnd_tag();
        return ($urandom_range(0, 1) == 0) ? '0 : ROB_TAG_W'($urandom_range(1, 15));
    endfunction

    // Monitor: per-cycle status against the model, scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 64'(bus.out_valid), 64'(cur_ov));
            check("free_count", 64'(bus.free_count), 64'(cur_free));
            check("has_capacity", 64'(bus.has_capacity), 64'(cur_free != 0));
            if (cur_ov) begin
                check("slot_op", 64'(bus.out_op), 64'(cur_out.op));
                check("slot_Vj", 64'(bus.out_Vj), 64'(cur_out.vj));
                check("slot_rob", 64'(bus.out_rob_tag), 64'(cur_out.rob));
            end
            if (bus.out_valid && bus.out_ready && ena && !flush && !rst) begin
                iss_log.push_back(bus.out_rob_tag);
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 64'(bus.out_rob_tag), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    iss_t e;
                    e = exp_q.pop_front();
                    check("iss_op", 64'(bus.out_op), 64'(e.op));
                    check("iss_Vj", 64'(bus.out_Vj), 64'(e.vj));
                    check("iss_Vk", 64'(bus.out_Vk), 64'(e.vk));
                    check("iss_pc", 64'(bus.out_pc), 64'(e.pc));
                    check("iss_imm", 64'(bus.out_imm), 64'(e.imm));
                    check("iss_rob", 64'(bus.out_rob_tag), 64'(e.rob));
                end
            end
        end
    end

    initial begin
        m_seq_ctr = 0;
        m_ov = 1'b0;
        m_out = '0;
        for (int i = 0; i < RS_DEPTH; i++) m_ent[i] = '0;
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_free_count", 64'(bus.free_count), 64'(RS_DEPTH));
        check("rst_out_Vj", 64'(bus.out_Vj), 64'd0);
        check("rst_out_rob", 64'(bus.out_rob_tag), 64'd0);

        // Ready op straight through.
        set_disp(6'd1, 0, 0, 32'd5, 32'd7, 4'd3); tick();
        set_idle(); repeat (3) tick();

        // Wakeup via channel 1.
        set_disp(6'd2, 4'd4, 0, 32'd0, 32'd1, 4'd5); tick();
        set_idle(); set_cdb(1, 4'd4, 32'hAB); tick();
        set_idle(); repeat (3) tick();

        // Operand captured from the CDB in the dispatch cycle.
        set_disp(6'd3, 0, 4'd6, 32'd11, 32'd0, 4'd7); set_cdb(0, 4'd6, 32'd9); tick();
        set_idle(); repeat (3) tick();

        // Fill, overflow, then mass wakeup.
        for (int k = 0; k < RS_DEPTH; k++) begin
            set_disp(OP_W'(k), 4'd2, 0, 32'd0, 32'(k), ROB_TAG_W'(k)); tick();
        end
        check("full_free_count", 64'(bus.free_count), 64'd0);
        check("full_has_capacity", 64'(bus.has_capacity), 64'd0);
        set_disp(6'd63, 0, 0, 32'd1, 32'd1, 4'd15); tick();
        check("overflow_free_count", 64'(bus.free_count), 64'd0);
        iss_log.delete();
        set_idle(); set_cdb(0, 4'd2, 32'h22); tick();
        set_idle(); repeat (RS_DEPTH + 4) tick();
        check("drain_issues", 64'(iss_log.size()), 64'(RS_DEPTH));
        check("drain_free_count", 64'(bus.free_count), 64'(RS_DEPTH));

        // Stalled issue slot, then flush.
        for (int k = 0; k < 3; k++) begin
            set_idle(); bus.out_ready = 1'b0;
            set_disp(OP_W'(40 + k), 0, 0, 32'(100 + k), 32'(200 + k), ROB_TAG_W'(8 + k)); tick();
        end
        set_idle(); bus.out_ready = 1'b0; repeat (6) tick();
        flush = 1'b1; tick();
        set_idle(); tick();
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_free_count", 64'(bus.free_count), 64'(RS_DEPTH));

        // A lands in slot 2, B later in slot 1, both woken together.
        iss_log.delete();
        set_disp(6'd1, 4'd7, 0, 0, 0, 4'd1); tick();
        set_disp(6'd2, 4'd8, 0, 0, 0, 4'd2); tick();
        set_disp(6'd3, 4'd9, 0, 0, 0, 4'd3); tick();
        set_idle(); set_cdb(0, 4'd9, 32'h9); tick();
        set_idle(); repeat (3) tick();
        set_disp(6'd10, 4'd10, 0, 0, 0, 4'd10); tick();
        set_idle(); set_cdb(1, 4'd8, 32'h8); tick();
        set_idle(); repeat (3) tick();
        set_disp(6'd11, 4'd10, 0, 0, 0, 4'd11); tick();
        set_idle(); tick();
        set_cdb(0, 4'd10, 32'hA0); tick();
        set_idle(); repeat (4) tick();
        check("age_count", 64'(iss_log.size()), 64'd4);
        if (iss_log.size() >= 4) begin
            check("age_first", 64'(iss_log[2]), OLDEST ? 64'd10 : 64'd11);
            check("age_second", 64'(iss_log[3]), OLDEST ? 64'd11 : 64'd10);
        end
        set_cdb(1, 4'd7, 32'h7); tick();
        set_idle(); repeat (3) tick();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            ena   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 99) == 0);
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.assignment_ena = ($urandom_range(0, 1) != 0);
            bus.in_op     = OP_W'($urandom);
            bus.in_Qj     = rnd_tag();
            bus.in_Qk     = rnd_tag();
            bus.in_Vj     = $urandom;
            bus.in_Vk     = $urandom;
            bus.in_pc     = $urandom;
            bus.in_imm    = $urandom;
            bus.in_rd_rob = ROB_TAG_W'($urandom);
            for (int c = 0; c < NUM_CDB; c++) begin
                cdb_v[c] = ($urandom_range(0, 2) == 0);
                cdb_t[c] = ROB_TAG_W'($urandom_range(0, 15));
                cdb_d[c] = $urandom;
            end
            tick();
        end

        // Broadcast every tag repeatedly so the station empties.
        set_idle();
        for (int n = 0; n < 64; n++) begin
            set_cdb(0, ROB_TAG_W'((n % 15) + 1), $urandom);
            tick();
        end
        set_idle(); repeat (RS_DEPTH + 4) tick();
        check("final_free_count", 64'(bus.free_count), 64'(RS_DEPTH));
        check("final_out_valid", 64'(bus.out_valid), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
